// File: rtl/sample0_mac_pkg.sv
// Shared types, constants and width helpers for the sample0 MAC pipeline.
package sample0_mac_pkg;

    localparam int unsigned MIN_NUM_STAGE = 3;
    localparam int unsigned MAX_NUM_STAGE = 8;

    // Per-beat control that travels alongside the product.
    typedef struct packed {
        logic vld;
        logic acc_en;
        logic acc_clr;
    } sideband_t;

    localparam int unsigned SB_W = $bits(sideband_t);

    // Width of the full signed product of two operands.
    function automatic int unsigned PROD_W(input int unsigned w0, input int unsigned w1);
        return w0 + w1;
    endfunction

endpackage

// File: rtl/sample0_mac_delay.sv
// Generic ce-gated, synchronously reset shift register; DEPTH=0 degenerates to a wire.
module sample0_mac_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        // Control inputs have no function without storage.
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, reset, ce};
        assign dout = din;
    end else begin : g_reg
        logic [WIDTH-1:0] taps [DEPTH];

        // Shift one tap per enabled cycle; reset flushes every tap.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int unsigned i = 0; i < DEPTH; i++) taps[i] <= '0;
            end else if (ce) begin
                taps[0] <= din;
                for (int unsigned i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
            end
        end

        assign dout = taps[DEPTH-1];
    end

endmodule

// File: rtl/sample0_mac_pipe.sv
// Pipelined, ce-gated signed multiply-accumulate unit.
// Optional macro SAMPLE0_MAC_SAT_EN: clamp dout to dout_WIDTH and flag clamps on dout_ovf;
// otherwise dout wraps and dout_ovf is tied low.
module sample0_mac_pipe
    import sample0_mac_pkg::*;
#(
    parameter int unsigned din0_WIDTH = 11,
    parameter int unsigned din1_WIDTH = 11,
    parameter int unsigned dout_WIDTH = 11,
    parameter int unsigned ACC_WIDTH  = 30,
    parameter int unsigned NUM_STAGE  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  din_vld,
    input  logic                  acc_en,
    input  logic                  acc_clr,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  dout_vld,
    output logic                  dout_ovf
);

    localparam int unsigned PW = PROD_W(din0_WIDTH, din1_WIDTH);

    if (NUM_STAGE < MIN_NUM_STAGE || NUM_STAGE > MAX_NUM_STAGE) begin : g_bad_stage
        $error("sample0_mac_pipe: NUM_STAGE=%0d outside legal range", NUM_STAGE);
    end
    if (ACC_WIDTH < PW || ACC_WIDTH < dout_WIDTH) begin : g_bad_acc
        $error("sample0_mac_pipe: ACC_WIDTH=%0d too narrow", ACC_WIDTH);
    end

    logic signed [din0_WIDTH-1:0] a_q;
    logic signed [din1_WIDTH-1:0] b_q;
    sideband_t                    sb1_q;

    // Stage 1: register operands and sideband.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            sb1_q <= '0;
        end else if (ce) begin
            a_q   <= din0;
            b_q   <= din1;
            sb1_q <= {din_vld, acc_en, acc_clr};
        end
    end

    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] p2_q;
    sideband_t                   sb2_q;

    assign prod = PW'(a_q) * PW'(b_q);

    // Stage 2: full-width signed product, sign-extended to the accumulator width.
    always_ff @(posedge clk) begin
        if (reset) begin
            p2_q  <= '0;
            sb2_q <= '0;
        end else if (ce) begin
            p2_q  <= ACC_WIDTH'(prod);
            sb2_q <= sb1_q;
        end
    end

    logic [ACC_WIDTH+SB_W-1:0]   pipe_out;
    logic signed [ACC_WIDTH-1:0] p3;
    sideband_t                   sb3;

    sample0_mac_delay #(
        .WIDTH (ACC_WIDTH + SB_W),
        .DEPTH (NUM_STAGE - MIN_NUM_STAGE)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .din   ({p2_q, sb2_q}),
        .dout  (pipe_out)
    );

    assign {p3, sb3} = pipe_out;

    logic signed [ACC_WIDTH-1:0] acc_q;
    logic                        vld_q;

    // Final stage: accumulate or reload on valid beats; invalid beats hold the sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            vld_q <= 1'b0;
        end else if (ce) begin
            vld_q <= sb3.vld;
            if (sb3.vld) begin
                acc_q <= (sb3.acc_clr || !sb3.acc_en) ? p3 : acc_q + p3;
            end
        end
    end

    assign dout_vld = vld_q;

`ifdef SAMPLE0_MAC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    // Clamp the held accumulator into the output range and flag when clamping.
    always_comb begin
        dout     = acc_q[dout_WIDTH-1:0];
        dout_ovf = 1'b0;
        if (acc_q > SAT_MAX) begin
            dout     = {1'b0, {(dout_WIDTH-1){1'b1}}};
            dout_ovf = 1'b1;
        end else if (acc_q < SAT_MIN) begin
            dout     = {1'b1, {(dout_WIDTH-1){1'b0}}};
            dout_ovf = 1'b1;
        end
    end
`else
    assign dout     = acc_q[dout_WIDTH-1:0];
    assign dout_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_sample0_mac_pipe.sv
// Scoreboard bench for sample0_mac_pipe: a default instance for directed and random beats,
// and a NUM_STAGE=6, 16x8 instance for random beats.
module tb_sample0_mac_pipe;

    localparam int ACCW = 30;
    localparam int NS0  = 3;
    localparam int NS1  = 6;
    localparam int DW   = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        ce0, vld0, en0, clr0, dvld0, ovf0;
    logic [10:0] a0, b0, dout0;
    logic        ce1, vld1, en1, clr1, dvld1, ovf1;
    logic [15:0] a1;
    logic [7:0]  b1;
    logic [10:0] dout1;

    sample0_mac_pipe u_dut0 (
        .clk(clk), .reset(reset), .ce(ce0), .din0(a0), .din1(b0), .din_vld(vld0),
        .acc_en(en0), .acc_clr(clr0), .dout(dout0), .dout_vld(dvld0), .dout_ovf(ovf0)
    );

    sample0_mac_pipe #(
        .din0_WIDTH(16), .din1_WIDTH(8), .dout_WIDTH(DW), .ACC_WIDTH(ACCW), .NUM_STAGE(NS1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .ce(ce1), .din0(a1), .din1(b1), .din_vld(vld1),
        .acc_en(en1), .acc_clr(clr1), .dout(dout1), .dout_vld(dvld1), .dout_ovf(ovf1)
    );

    typedef struct {
        longint      d;
        bit          ovf;
        int unsigned due;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    longint      acc_m[2];
    int unsigned cc[2];
    int          checks = 0;
    int          errors = 0;

    // Count enabled clock edges per instance; used to verify latency.
    initial begin cc[0] = 0; cc[1] = 0; acc_m[0] = 0; acc_m[1] = 0; end
    always @(posedge clk) begin
        if (ce0 === 1'b1) cc[0]++;
        if (ce1 === 1'b1) cc[1]++;
    end

    function automatic longint wrapw(longint x, int w);
        return (x <<< (64 - w)) >>> (64 - w);
    endfunction

    // Reference: running sum with reload/accumulate, then wrap or clamp to the output width.
    function automatic exp_t predict(int i, longint a, longint b, bit en, bit clr, int ns);
        exp_t   e;
        longint p, hi, lo, one;
        one = 1;
        p   = a * b;
        if (clr || !en) acc_m[i] = p;
        else            acc_m[i] = wrapw(acc_m[i] + p, ACCW);
        hi = (one <<< (DW - 1)) - 1;
        lo = -(one <<< (DW - 1));
`ifdef SAMPLE0_MAC_SAT_EN
        if (acc_m[i] > hi)      begin e.d = hi; e.ovf = 1'b1; end
        else if (acc_m[i] < lo) begin e.d = lo; e.ovf = 1'b1; end
        else                    begin e.d = acc_m[i]; e.ovf = 1'b0; end
`else
        e.d   = wrapw(acc_m[i], DW);
        e.ovf = 1'b0;
`endif
        e.due = cc[i] + ns;
        return e;
    endfunction

    task automatic cmp(input string nm, input exp_t e, input longint d, input bit ovf,
                       input int unsigned now);
        checks++;
        if (e.d != d || e.ovf != ovf || e.due != now) begin
            errors++;
            $display("FAIL %s: got dout=%0d ovf=%0d edge=%0d, want dout=%0d ovf=%0d edge=%0d",
                     nm, d, ovf, now, e.d, e.ovf, e.due);
        end
    endtask

    // Monitors: an output is consumed when ce && dout_vld at the next edge.
    always @(negedge clk) begin
        if (ce0 === 1'b1 && dvld0 === 1'b1) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL out0: unexpected dout_vld with dout=%0d, want no output", $signed(dout0));
            end else begin
                cmp("out0", q0.pop_front(), longint'($signed(dout0)), ovf0, cc[0]);
            end
        end
    end

    always @(negedge clk) begin
        if (ce1 === 1'b1 && dvld1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL out1: unexpected dout_vld with dout=%0d, want no output", $signed(dout1));
            end else begin
                cmp("out1", q1.pop_front(), longint'($signed(dout1)), ovf1, cc[1]);
            end
        end
    end

    task automatic step0(input bit ce, input longint a, input longint b, input bit vld,
                         input bit en, input bit clr);
        ce0 = ce; a0 = a[10:0]; b0 = b[10:0]; vld0 = vld; en0 = en; clr0 = clr;
        if (ce && vld)
            q0.push_back(predict(0, longint'($signed(a0)), longint'($signed(b0)), en, clr, NS0));
        @(posedge clk); #1;
    endtask

    task automatic step1(input bit ce, input longint a, input longint b, input bit vld,
                         input bit en, input bit clr);
        ce1 = ce; a1 = a[15:0]; b1 = b[7:0]; vld1 = vld; en1 = en; clr1 = clr;
        if (ce && vld)
            q1.push_back(predict(1, longint'($signed(a1)), longint'($signed(b1)), en, clr, NS1));
        @(posedge clk); #1;
    endtask

    task automatic idle0(input int n);
        for (int i = 0; i < n; i++) step0(1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // One-cycle reset: beats not yet presented are discarded and the sum restarts at 0.
    task automatic do_reset();
        reset = 1'b1; ce0 = 1'b1; ce1 = 1'b1; vld0 = 1'b0; vld1 = 1'b0;
        while (q0.size() > 0 && q0[$].due > cc[0]) void'(q0.pop_back());
        while (q1.size() > 0 && q1[$].due > cc[1]) void'(q1.pop_back());
        acc_m[0] = 0; acc_m[1] = 0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic drain_check(input string nm, input int pending);
        checks++;
        if (pending != 0) begin
            errors++;
            $display("FAIL %s: %0d results never appeared, want 0", nm, pending);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        ce0 = 1'b1; a0 = '0; b0 = '0; vld0 = 1'b0; en0 = 1'b0; clr0 = 1'b0;
        ce1 = 1'b1; a1 = '0; b1 = '0; vld1 = 1'b0; en1 = 1'b0; clr1 = 1'b0;
        @(posedge clk); #1;
        do_reset();

        checks++;
        if (dout0 !== '0 || dvld0 !== 1'b0 || ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL reset0: got dout=%0d vld=%0b ovf=%0b, want 0 0 0", dout0, dvld0, ovf0);
        end
        checks++;
        if (dout1 !== '0 || dvld1 !== 1'b0 || ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL reset1: got dout=%0d vld=%0b ovf=%0b, want 0 0 0", dout1, dvld1, ovf1);
        end

        // Single pass-through product.
        step0(1'b1, 12, -5, 1'b1, 1'b0, 1'b0);
        idle0(4);

        // Back-to-back accumulate chain.
        step0(1'b1, 3, 4, 1'b1, 1'b0, 1'b1);
        step0(1'b1, 5, 6, 1'b1, 1'b1, 1'b0);
        step0(1'b1, 7, 8, 1'b1, 1'b1, 1'b0);
        idle0(4);

        // Same chain with ce low for two cycles; stray vld while frozen is ignored.
        step0(1'b1, 3, 4, 1'b1, 1'b0, 1'b1);
        step0(1'b1, 5, 6, 1'b1, 1'b1, 1'b0);
        step0(1'b0, 9, 9, 1'b1, 1'b1, 1'b0);
        step0(1'b0, 9, 9, 1'b1, 1'b1, 1'b0);
        step0(1'b1, 7, 8, 1'b1, 1'b1, 1'b0);
        idle0(4);

        // Output range corners and clr winning over en.
        step0(1'b1, 1000, 1000, 1'b1, 1'b0, 1'b0);
        step0(1'b1, -1024, -1024, 1'b1, 1'b0, 1'b0);
        step0(1'b1, -1000, 1000, 1'b1, 1'b0, 1'b0);
        step0(1'b1, 10, 10, 1'b1, 1'b1, 1'b0);
        step0(1'b1, 3, 3, 1'b1, 1'b1, 1'b1);
        idle0(4);

        // Reset with two beats in flight, then accumulate from zero.
        step0(1'b1, 9, 9, 1'b1, 1'b0, 1'b1);
        step0(1'b1, 4, 4, 1'b1, 1'b1, 1'b0);
        do_reset();
        step0(1'b1, 2, 3, 1'b1, 1'b1, 1'b0);
        idle0(5);
        drain_check("drain_directed", q0.size());

        fork
            begin
                for (int i = 0; i < 1000; i++)
                    step0($urandom_range(0, 3) != 0, longint'($urandom), longint'($urandom),
                          $urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 7) == 0);
                idle0(8);
            end
            begin
                for (int i = 0; i < 1000; i++)
                    step1($urandom_range(0, 3) != 0, longint'($urandom), longint'($urandom),
                          $urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 7) == 0);
                for (int i = 0; i < 10; i++) step1(1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
            end
        join
        drain_check("drain_rand0", q0.size());
        drain_check("drain_rand1", q1.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
